wq_rptr_decode: RTL and testbench

- Write-domain receiver for the read-side Gray pointer of the async FIFO; decoder counterpart to the write pointer's binary-to-Gray encoder.
- Synchronizes the read pointer into wclk and decodes Gray to binary.
- Computes the FIFO fill level seen from the write side and raises a programmable almost-full flag.
- Checks that the incoming Gray stream changes at most one bit per cycle, and flags overflow, for protocol/CDC checking.

---
 rtl/wq_rptr_decode.sv | 115 +++++++++++
 tb/tb_wq_rptr_decode.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wq_rptr_decode.sv
// Write-domain receiver for the async FIFO read pointer: two-flop Gray synchronizer,
// Gray-to-binary decode, fill level, almost-full flag and sticky protocol checkers.
module wq_rptr_decode #(
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic [ADDRSIZE:0]   wbin,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                err_clr,
  output logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wq2_rbin,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  output logic                wgray_err,
  output logic                wovf_err
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  typedef enum logic [1:0] {
    COLD  = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    ARMED = 2'd3
  } prime_e;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [7:0] popcount(input logic [PW-1:0] v);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < PW; i++) begin
      cnt = cnt + 8'(v[i]);
    end
    return cnt;
  endfunction

  logic [PW-1:0] wq1_q, wq1_d;
  logic [PW-1:0] wq2_q, wq2_d;
  logic [PW-1:0] wq3_q, wq3_d;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          afull_q, afull_d;
  logic          gray_err_q, gray_err_d;
  logic          ovf_err_q, ovf_err_d;
  prime_e        prime_q, prime_d;
  logic          armed_s;
  logic          gray_set_s;
  logic          ovf_set_s;

  // Next-state logic; checks stay masked until the pipeline has refilled after reset.
  always_comb begin
    wq1_d      = rptr;
    wq2_d      = wq1_q;
    wq3_d      = wq2_q;
    rbin_d     = gray2bin(wq2_q);
    wlevel_d   = wbin - rbin_q;
    afull_d    = (wlevel_d >= afull_thresh);
    armed_s    = (prime_q == ARMED);
    gray_set_s = armed_s && (popcount(wq2_q ^ wq3_q) > 8'd1);
    ovf_set_s  = armed_s && (wlevel_d > DEPTH);
    gray_err_d = gray_set_s | (gray_err_q & ~err_clr);
    ovf_err_d  = ovf_set_s | (ovf_err_q & ~err_clr);
    case (prime_q)
      COLD:    prime_d = FILL1;
      FILL1:   prime_d = FILL2;
      FILL2:   prime_d = ARMED;
      ARMED:   prime_d = ARMED;
      default: prime_d = COLD;
    endcase
  end

  // All state, cleared asynchronously.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_q      <= '0;
      wq2_q      <= '0;
      wq3_q      <= '0;
      rbin_q     <= '0;
      wlevel_q   <= '0;
      afull_q    <= 1'b0;
      gray_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
      prime_q    <= COLD;
    end else begin
      wq1_q      <= wq1_d;
      wq2_q      <= wq2_d;
      wq3_q      <= wq3_d;
      rbin_q     <= rbin_d;
      wlevel_q   <= wlevel_d;
      afull_q    <= afull_d;
      gray_err_q <= gray_err_d;
      ovf_err_q  <= ovf_err_d;
      prime_q    <= prime_d;
    end
  end

  assign wq2_rptr     = wq2_q;
  assign wq2_rbin     = rbin_q;
  assign wlevel       = wlevel_q;
  assign walmost_full = afull_q;
  assign wgray_err    = gray_err_q;
  assign wovf_err     = ovf_err_q;

endmodule

// File: tb/tb_wq_rptr_decode.sv
// Directed bench for wq_rptr_decode (ADDRSIZE=4): priming, decode sweep, almost-full,
// wrap, Gray error with err_clr, and asynchronous mid-run reset.
module tb_wq_rptr_decode;

  logic       wclk;
  logic       wrst_n;
  logic [4:0] rptr;
  logic [4:0] wbin;
  logic [4:0] afull_thresh;
  logic       err_clr;
  logic [4:0] wq2_rptr;
  logic [4:0] wq2_rbin;
  logic [4:0] wlevel;
  logic       walmost_full;
  logic       wgray_err;
  logic       wovf_err;

  int vectors;
  int miscompares;

  wq_rptr_decode #(.ADDRSIZE(4)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .rptr         (rptr),
    .wbin         (wbin),
    .afull_thresh (afull_thresh),
    .err_clr      (err_clr),
    .wq2_rptr     (wq2_rptr),
    .wq2_rbin     (wq2_rbin),
    .wlevel       (wlevel),
    .walmost_full (walmost_full),
    .wgray_err    (wgray_err),
    .wovf_err     (wovf_err)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] v;
    v = 5'(n);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wq2_rptr"}, 32'(wq2_rptr), 32'd0);
    check({tag, "_wq2_rbin"}, 32'(wq2_rbin), 32'd0);
    check({tag, "_wlevel"},   32'(wlevel),   32'd0);
    check({tag, "_afull"},    32'(walmost_full), 32'd0);
    check({tag, "_gray_err"}, 32'(wgray_err), 32'd0);
    check({tag, "_ovf_err"},  32'(wovf_err),  32'd0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    wrst_n       = 1'b1;
    rptr         = 5'b00011;
    wbin         = 5'd7;
    afull_thresh = 5'd12;
    err_clr      = 1'b0;

    // 1. reset and priming with a nonzero pointer at release
    #1 wrst_n = 1'b0;
    #2;
    check_all_zero("rst_async");
    step(2);
    check_all_zero("rst_held");
    @(negedge wclk);
    wrst_n = 1'b1;
    step(1);
    check("prime_wq2_e1", 32'(wq2_rptr), 32'd0);
    step(1);
    check("prime_wq2_e2", 32'(wq2_rptr), 32'd3);
    step(1);
    check("prime_rbin_e3", 32'(wq2_rbin), 32'd2);
    step(1);
    check("prime_level_e4", 32'(wlevel), 32'd5);
    check("prime_afull", 32'(walmost_full), 32'd0);
    step(4);
    check("prime_gray_err", 32'(wgray_err), 32'd0);
    check("prime_ovf_err", 32'(wovf_err), 32'd0);

    // settle to zero and clear anything raised by the 3 -> 0 jump
    rptr = 5'd0;
    wbin = 5'd0;
    step(5);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("pre_sweep_gray", 32'(wgray_err), 32'd0);
    check("pre_sweep_ovf", 32'(wovf_err), 32'd0);

    // 2. decode sweep over the full Gray sequence
    for (int k = 0; k < 32; k++) begin
      rptr = gray5(k);
      step(4);
      check("sweep_rbin", 32'(wq2_rbin), 32'(k));
      check("sweep_level", 32'(wlevel), 32'((32 - k) % 32));
      check("sweep_afull", 32'(walmost_full), 32'(((32 - k) % 32) >= 12));
      check("sweep_ovf", 32'(wovf_err), 32'(k >= 1));
      check("sweep_gray", 32'(wgray_err), 32'd0);
    end

    // 3. almost full threshold and exact-full boundary
    rptr = 5'd0;
    wbin = 5'd0;
    step(4);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("af_clr_ovf", 32'(wovf_err), 32'd0);
    for (int w = 0; w <= 16; w++) begin
      wbin = 5'(w);
      step(1);
      check("af_level", 32'(wlevel), 32'(w));
      check("af_flag", 32'(walmost_full), 32'(w >= 12));
      check("af_ovf", 32'(wovf_err), 32'd0);
    end
    wbin = 5'd17;
    step(1);
    check("af_level17", 32'(wlevel), 32'd17);
    check("af_ovf17", 32'(wovf_err), 32'd1);

    // 5. wrap-around of the read pointer
    wbin = 5'd0;
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("wrap_clr_ovf", 32'(wovf_err), 32'd0);
    wbin = 5'd18;
    rptr = 5'b10000;
    step(4);
    check("wrap_wq2", 32'(wq2_rptr), 32'd16);
    check("wrap_rbin", 32'(wq2_rbin), 32'd31);
    check("wrap_level", 32'(wlevel), 32'd19);
    check("wrap_ovf", 32'(wovf_err), 32'd1);
    check("wrap_gray", 32'(wgray_err), 32'd0);
    wbin = 5'd3;
    step(1);
    check("wrap_level4", 32'(wlevel), 32'd4);
    check("wrap_afull4", 32'(walmost_full), 32'd0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("wrap_ovf_clr", 32'(wovf_err), 32'd0);
    step(2);
    check("wrap_ovf_quiet", 32'(wovf_err), 32'd0);
    check("wrap_level_hold", 32'(wlevel), 32'd4);

    // 4. Gray error detection, clear, and set-wins-over-clear
    wbin = 5'd1;
    rptr = 5'b00001;
    step(5);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("ge_base_gray", 32'(wgray_err), 32'd0);
    check("ge_base_ovf", 32'(wovf_err), 32'd0);
    check("ge_base_rbin", 32'(wq2_rbin), 32'd1);
    check("ge_base_level", 32'(wlevel), 32'd0);
    rptr = 5'b00110;
    wbin = 5'd5;
    step(2);
    check("ge_wq2_jump", 32'(wq2_rptr), 32'd6);
    check("ge_not_yet", 32'(wgray_err), 32'd0);
    step(1);
    check("ge_set", 32'(wgray_err), 32'd1);
    check("ge_rbin4", 32'(wq2_rbin), 32'd4);
    step(3);
    check("ge_sticky", 32'(wgray_err), 32'd1);
    check("ge_level1", 32'(wlevel), 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("ge_cleared", 32'(wgray_err), 32'd0);
    rptr = 5'b00001;
    step(2);
    check("ge2_wq2", 32'(wq2_rptr), 32'd1);
    check("ge2_pre", 32'(wgray_err), 32'd0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("ge2_set_wins", 32'(wgray_err), 32'd1);

    // 6. asynchronous reset between edges, then re-priming with a false Gray step
    #2 wrst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    rptr = 5'b00110;
    @(negedge wclk);
    wrst_n = 1'b1;
    step(2);
    check("midrst_wq2", 32'(wq2_rptr), 32'd6);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("midrst_no_gray", 32'(wgray_err), 32'd0);
    end
    check("midrst_level", 32'(wlevel), 32'd1);
    check("midrst_afull", 32'(walmost_full), 32'd0);
    check("midrst_ovf", 32'(wovf_err), 32'd0);

    // zero threshold forces almost-full
    afull_thresh = 5'd0;
    step(1);
    check("thresh0_afull", 32'(walmost_full), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
